onehot_sel_reg: RTL and testbench
=================================

// Module: onehot_sel_reg
// PURPOSE
//  Parametrised successor of the 4-way one-hot result selector. Selects one of
//  CH operand/result buses of WIDTH bits with a one-hot select. Registers the
//  chosen bus behind a valid/ready handshake, so the calculator datapath and
//  the display driver can stall independently.
//  Flags illegal (zero or multi-hot) selects with a sticky error bit.
// PARAMETERS
//  WIDTH     16  bits per channel
//  CH        4   number of input channels (>=2)
//  SCAN_DIV  16  cycles per channel in auto-scan mode (>=1); used only with SCAN_MODE_EN
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous reset, active-high
//  in_bus     in   CH*WIDTH    channel i = in_bus[i*WIDTH +: WIDTH]
//  sel        in   CH          one-hot channel select
//  in_valid   in   1           request to capture the selected channel
//  in_ready   out  1           capture accepted this cycle when in_valid && in_ready
//  out        out  WIDTH       registered selected data
//  out_ch     out  CHW         index of captured channel, CHW = $clog2(CH)
//  out_valid  out  1           out/out_ch hold an unconsumed value
//  out_ready  in   1           consumer takes out this cycle when out_valid && out_ready
//  sel_err    out  1           sticky: an illegal sel was captured
//  err_clr    in   1           clears sel_err
//  scan       in   1           auto-scan enable (present only with SCAN_MODE_EN)
// BEHAVIOUR
//  - Reset values: out=0, out_ch=0, out_valid=0, sel_err=0. Scan counter=0, scan ptr=0.
//  - in_ready = !out_valid || out_ready. This is combinational; a full register that is
//    being drained accepts a new capture in the same cycle.
//  - Capture (in_valid && in_ready): out/out_ch update on the next edge (latency 1),
//    and out_valid is set to 1.
//  - Legal sel (exactly one bit set, bit i): out <= channel i, out_ch <= i.
//  - Illegal sel (0 or >1 bits set): out <= 0, out_ch <= 0, out_valid <= 1, sel_err <= 1.
//  - Drain only (out_valid && out_ready, no capture): out_valid <= 0.
//    out and out_ch keep their last value.
//  - Capture and drain in the same cycle: out_valid stays 1 with the new data. No bubble.
//  - No capture while out_valid && !out_ready: out, out_ch and out_valid are held stable.
//  - in_bus/sel changes while the register is not capturing have no effect on out.
//  - sel_err: set by an illegal capture, cleared by err_clr. If both happen in the same
//    cycle, set wins.
//  - Reset mid-transfer discards any held value. in_ready returns to 1 in the first
//    cycle after reset.
// CONFIGURATION
//  SCAN_MODE_EN defined:
//  - Adds the scan port, a cycle counter (0..SCAN_DIV-1) and a channel pointer (0..CH-1).
//  - scan=1: sel and in_valid are ignored. The counter increments every cycle.
//  - At terminal count (SCAN_DIV-1) an internal request is raised for one-hot(ptr).
//  - When that request is accepted (in_ready=1), ptr advances, wrapping CH-1 -> 0, and the
//    counter restarts at 0.
//  - If in_ready=0 at terminal count, the counter and request hold until the request is
//    accepted.
//  - scan 1->0: counter and ptr are reset to 0 and normal sel/in_valid operation resumes
//    on the next cycle.
//  - scan 0->1: the first capture is channel 0 after SCAN_DIV cycles.
//  SCAN_MODE_EN undefined: no scan port, no counter or pointer logic; behaviour is exactly
//  the non-scan description above.
// TESTING (WIDTH=16, CH=4, in_bus={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA})
//  1. Reset asserted 2 cycles -> out=0, out_valid=0, sel_err=0, in_ready=1.
//  2. sel=4'b0100, in_valid=1 for 1 cycle, out_ready=1
//     -> next cycle out=16'hCCCC, out_ch=2, out_valid=1; cleared the cycle after.
//  3. out_ready=0, captures of sel=0001 then 1000 -> first captured (AAAA), in_ready=0 and
//     out held; raise out_ready with in_valid=1 (sel=1000)
//     -> next cycle out=DDDD, out_valid still 1.
//  4. sel=4'b0110 captured -> out=0, out_ch=0, sel_err=1. sel_err stays 1 over legal
//     captures until err_clr=1. err_clr=1 coincident with sel=0 capture -> sel_err stays 1.
//  5. Reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, out=0,
//     in_ready=1.
//  6. (SCAN_MODE_EN, SCAN_DIV=4) scan=1, out_ready=1 -> captures every 4 cycles with out_ch
//     0,1,2,3,0 and data AAAA,BBBB,CCCC,DDDD,AAAA. Hold out_ready=0 for 10 cycles -> no
//     channel skipped.

Source files
------------

// File: rtl/onehot_sel_reg.sv
// onehot_sel_reg: one-hot channel selector with a registered valid/ready output stage.
// Define SCAN_MODE_EN to add the auto-scan request source and its scan port.
module onehot_sel_reg #(
  parameter int WIDTH    = 16,
  parameter int CH       = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH*WIDTH-1:0]     in_bus,
  input  logic [CH-1:0]           sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out,
  output logic [$clog2(CH)-1:0]   out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef SCAN_MODE_EN
  input  logic                    scan,
`endif
  output logic                    sel_err,
  input  logic                    err_clr
);

  localparam int CHW = $clog2(CH);

  // Reject configurations the selector cannot represent.
  if (CH < 2) begin : g_bad_ch
    $error("onehot_sel_reg: CH must be at least 2");
  end
  if (SCAN_DIV < 1) begin : g_bad_div
    $error("onehot_sel_reg: SCAN_DIV must be at least 1");
  end

  logic            req_valid;
  logic [CH-1:0]   req_sel;
  logic            cap;
  logic            legal;
  logic [WIDTH-1:0] hit_data;
  logic [CHW-1:0]  hit_idx;

`ifdef SCAN_MODE_EN
  localparam int CNTW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNTW-1:0] CNT_TC = CNTW'(SCAN_DIV - 1);
  localparam logic [CHW-1:0]  PTR_TC = CHW'(CH - 1);

  logic [CNTW-1:0] cnt;
  logic [CHW-1:0]  ptr;
  logic            scan_req;

  assign scan_req = (cnt == CNT_TC);

  // Scan mode overrides the external request with one-hot(ptr) at terminal count.
  always_comb begin
    req_valid = in_valid;
    req_sel   = sel;
    if (scan) begin
      req_valid    = scan_req;
      req_sel      = '0;
      req_sel[ptr] = 1'b1;
    end
  end

  // Divider and channel pointer; a stalled request holds at terminal count.
  always_ff @(posedge clk) begin
    if (rst || !scan) begin
      cnt <= '0;
      ptr <= '0;
    end else if (scan_req) begin
      if (in_ready) begin
        cnt <= '0;
        ptr <= (ptr == PTR_TC) ? '0 : ptr + 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign req_valid = in_valid;
  assign req_sel   = sel;
`endif

  assign in_ready = !out_valid || out_ready;
  assign cap      = req_valid && in_ready;
  assign legal    = (req_sel != '0) &&
                    ((req_sel & (req_sel - 1'b1)) == '0);

  // AND-OR mux of the selected channel and its index.
  always_comb begin
    hit_data = '0;
    hit_idx  = '0;
    for (int i = 0; i < CH; i++) begin
      if (req_sel[i]) begin
        hit_data = hit_data | in_bus[i*WIDTH +: WIDTH];
        hit_idx  = hit_idx | CHW'(i);
      end
    end
  end

  // Output register: capture (with optional same-cycle drain) or drain only.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (cap) begin
      out       <= legal ? hit_data : '0;
      out_ch    <= legal ? hit_idx : '0;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky illegal-select flag; a new error wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (cap && !legal) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_sel_reg.sv
// tb_onehot_sel_reg: directed stimulus with a scoreboard queue
// popped by a monitor on every output handshake.
module tb_onehot_sel_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_bus;
  logic [3:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;
  logic        err_clr;
`ifdef SCAN_MODE_EN
  logic        scan;
`endif

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  onehot_sel_reg #(
    .WIDTH(16),
    .CH(4),
    .SCAN_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_bus(in_bus),
    .sel(sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out(out),
    .out_ch(out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SCAN_MODE_EN
    .scan(scan),
`endif
    .sel_err(sel_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [15:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    sb.push_back(e);
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got out=%h ch=%0d required none",
                 out, out_ch);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_data", 32'(out), 32'(mon_e.d));
        chk("sb_ch", 32'(out_ch), 32'(mon_e.ch));
      end
    end
  end

  initial begin
    in_bus    = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    rst       = 1'b1;
    sel       = 4'b0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
`ifdef SCAN_MODE_EN
    scan      = 1'b0;
`endif

    // 1. reset
    tick();
    tick();
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_err", 32'(sel_err), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // 2. single capture, drained next cycle
    out_ready = 1'b1;
    sel = 4'b0100;
    in_valid = 1'b1;
    push(2'd2, 16'hCCCC);
    tick();
    in_valid = 1'b0;
    chk("t2_out", 32'(out), 32'hCCCC);
    chk("t2_ch", 32'(out_ch), 32'd2);
    chk("t2_valid", 32'(out_valid), 32'h1);
    tick();
    chk("t2_drained", 32'(out_valid), 32'h0);
    chk("t2_keep", 32'(out), 32'hCCCC);

    // 3. backpressure, then capture during drain
    out_ready = 1'b0;
    sel = 4'b0001;
    in_valid = 1'b1;
    push(2'd0, 16'hAAAA);
    tick();
    sel = 4'b1000;
    chk("t3_ready_lo", 32'(in_ready), 32'h0);
    chk("t3_first", 32'(out), 32'hAAAA);
    tick();
    chk("t3_held", 32'(out), 32'hAAAA);
    chk("t3_held_ch", 32'(out_ch), 32'd0);
    chk("t3_held_v", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    push(2'd3, 16'hDDDD);
    #1;
    chk("t3_ready_hi", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("t3_new", 32'(out), 32'hDDDD);
    chk("t3_no_bubble", 32'(out_valid), 32'h1);
    tick();
    chk("t3_drained", 32'(out_valid), 32'h0);

    // 4. illegal selects and sticky error
    sel = 4'b0110;
    in_valid = 1'b1;
    push(2'd0, 16'h0000);
    tick();
    in_valid = 1'b0;
    chk("t4_out0", 32'(out), 32'h0);
    chk("t4_ch0", 32'(out_ch), 32'd0);
    chk("t4_err", 32'(sel_err), 32'h1);
    sel = 4'b0010;
    in_valid = 1'b1;
    push(2'd1, 16'hBBBB);
    tick();
    in_valid = 1'b0;
    chk("t4_legal", 32'(out), 32'hBBBB);
    chk("t4_sticky", 32'(sel_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr", 32'(sel_err), 32'h0);
    sel = 4'b0000;
    in_valid = 1'b1;
    err_clr = 1'b1;
    push(2'd0, 16'h0000);
    tick();
    in_valid = 1'b0;
    err_clr = 1'b0;
    chk("t4_set_wins", 32'(sel_err), 32'h1);
    chk("t4_zero_ch", 32'(out_ch), 32'd0);
    chk("t4_zero_out", 32'(out), 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr2", 32'(sel_err), 32'h0);

    // 5. reset while holding a value
    out_ready = 1'b0;
    sel = 4'b0100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_full", 32'(out_valid), 32'h1);
    chk("t5_stall", 32'(in_ready), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'h0);
    chk("t5_out", 32'(out), 32'h0);
    chk("t5_ready", 32'(in_ready), 32'h1);

`ifdef SCAN_MODE_EN
    // 6. auto-scan, sel/in_valid ignored, stall without skipping
    push(2'd0, 16'hAAAA);
    push(2'd1, 16'hBBBB);
    push(2'd2, 16'hCCCC);
    push(2'd3, 16'hDDDD);
    push(2'd0, 16'hAAAA);
    push(2'd1, 16'hBBBB);
    push(2'd2, 16'hCCCC);
    push(2'd3, 16'hDDDD);
    out_ready = 1'b1;
    sel = 4'b0010;
    in_valid = 1'b1;
    scan = 1'b1;
    for (int n = 0; n < 200 && sb.size() > 3; n++) tick();
    chk("t6_first5", 32'(sb.size()), 32'd3);
    out_ready = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    chk("t6_stall_v", 32'(out_valid), 32'h1);
    chk("t6_stall_q", 32'(sb.size()), 32'd3);
    out_ready = 1'b1;
    for (int n = 0; n < 200 && sb.size() > 0; n++) tick();
    scan = 1'b0;
    in_valid = 1'b0;
    chk("t6_rest", 32'(sb.size()), 32'd0);
    tick();
    tick();
`endif

    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
